msx_ram_responder: RTL

- Memory-side responder for the slot subsystem's RAM request port (ram_addr/ram_din/ram_rnw/sdram_ce).
- Turns each request into one SDRAM transaction, returns ram_dout, and stretches the CPU cycle with cpu_wait until the data is valid or the write is accepted.
- Sits between msx_slots and the SDRAM controller.
- Enforces installed-SDRAM bounds and a response timeout.

---
 rtl/msx_ram_responder_pkg.sv | 25 ++
 rtl/msx_ram_responder_if.sv | 30 +++
 rtl/msx_ram_read_cache.sv | 52 +++++
 rtl/msx_ram_responder.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/msx_ram_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | msx_ram_responder_pkg: shared types and constants for the      |
// | slot RAM responder.                          Rev 1.0           |
// +----------------------------------------------------------------+
package msx_ram_responder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } ram_resp_state_t;

    localparam int SDRAM_BASE_SHIFT = 25;

    // Size code n selects 32MB << n; code 3 means no SDRAM fitted.
    function automatic logic addr_in_range(input logic [26:0] addr, input logic [1:0] size);
        logic [26:0] shifted;
        shifted = addr >> (SDRAM_BASE_SHIFT + int'(size));
        return (size != 2'd3) && (shifted == 27'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/msx_ram_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------+
// | msx_ram_responder_if: slot-side request bus and SDRAM-side     |
// | command bus of the RAM responder.            Rev 1.0           |
// +----------------------------------------------------------------+
interface msx_ram_responder_if;
    logic [26:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_rnw;
    logic        sdram_ce;
    logic [7:0]  ram_dout;
    logic        cpu_wait;
    logic [26:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_rd;
    logic        mem_we;
    logic [7:0]  mem_dout;
    logic        mem_ready;

    modport slave (
        input  ram_addr, ram_din, ram_rnw, sdram_ce, mem_dout, mem_ready,
        output ram_dout, cpu_wait, mem_addr, mem_din, mem_rd, mem_we
    );

    modport master (
        output ram_addr, ram_din, ram_rnw, sdram_ce, mem_dout, mem_ready,
        input  ram_dout, cpu_wait, mem_addr, mem_din, mem_rd, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/msx_ram_read_cache.sv
`default_nettype none
// +----------------------------------------------------------------+
// | msx_ram_read_cache: single-entry read cache used when          |
// | MSX_RAM_RESP_READ_CACHE_EN is defined.       Rev 1.0           |
// +----------------------------------------------------------------+
module msx_ram_read_cache (
    input  wire logic        clk_sys,
    input  wire logic        reset_n,
    input  wire logic [1:0]  sdram_size,
    input  wire logic [26:0] lookup_addr,
    output logic             hit,
    output logic [7:0]       hit_data,
    input  wire logic        fill_en,
    input  wire logic [26:0] fill_addr,
    input  wire logic [7:0]  fill_data,
    input  wire logic        write_en,
    input  wire logic [26:0] write_addr,
    input  wire logic [7:0]  write_data,
    input  wire logic        invalidate
);
    logic        r_valid;
    logic [26:0] r_tag;
    logic [7:0]  r_data;
    logic [1:0]  r_size_q;
    logic        w_size_chg;

    // A size change must already block a hit in the cycle it appears.
    assign w_size_chg = (sdram_size != r_size_q);
    assign hit        = r_valid && !w_size_chg && (r_tag == lookup_addr);
    assign hit_data   = r_data;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_valid  <= 1'b0;
            r_tag    <= '0;
            r_data   <= '0;
            r_size_q <= '0;
        end else begin
            r_size_q <= sdram_size;
            if (w_size_chg || invalidate) begin
                r_valid <= 1'b0;
            end else if (fill_en) begin
                r_valid <= 1'b1;
                r_tag   <= fill_addr;
                r_data  <= fill_data;
            end else if (write_en && r_valid && (r_tag == write_addr)) begin
                r_data  <= write_data;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/msx_ram_responder.sv
`default_nettype none
// +----------------------------------------------------------------+
// | msx_ram_responder: turns slot RAM requests into SDRAM commands |
// | with bounds check, timeout and CPU wait stretching.            |
// | Optional read cache: MSX_RAM_RESP_READ_CACHE_EN  Rev 1.0       |
// +----------------------------------------------------------------+
module msx_ram_responder
    import msx_ram_responder_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 64,
    parameter logic [7:0] OOR_DATA       = 8'hFF
) (
    input  wire logic          clk_sys,
    input  wire logic          reset_n,
    input  wire logic [1:0]    sdram_size,
    output logic               timeout_err,
    msx_ram_responder_if.slave bus
);
    localparam int             CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ram_resp_state_t r_state, w_next;
    logic             r_ce_q;
    logic             r_rnw;
    logic [CNT_W-1:0] r_cnt;
    logic [26:0]      r_mem_addr;
    logic [7:0]       r_mem_din;
    logic [7:0]       r_ram_dout;
    logic             r_timeout_err;
    logic             w_edge, w_in_range, w_timeout, w_hit;
    logic [7:0]       w_cache_data;
    logic             w_cpu_wait, w_mem_rd, w_mem_we;

    assign w_edge     = bus.sdram_ce && !r_ce_q;
    assign w_in_range = addr_in_range(bus.ram_addr, sdram_size);
    assign w_timeout  = (r_cnt == CNT_LAST);

`ifdef MSX_RAM_RESP_READ_CACHE_EN
    logic w_tag_hit;

    msx_ram_read_cache u_read_cache (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .sdram_size  (sdram_size),
        .lookup_addr (bus.ram_addr),
        .hit         (w_tag_hit),
        .hit_data    (w_cache_data),
        .fill_en     ((r_state == WAIT) && bus.mem_ready && r_rnw),
        .fill_addr   (r_mem_addr),
        .fill_data   (bus.mem_dout),
        .write_en    ((r_state == IDLE) && w_edge && w_in_range && !bus.ram_rnw),
        .write_addr  (bus.ram_addr),
        .write_data  (bus.ram_din),
        .invalidate  ((r_state == WAIT) && !bus.mem_ready && w_timeout)
    );

    assign w_hit = w_tag_hit && w_in_range && bus.ram_rnw;
`else
    assign w_hit        = 1'b0;
    assign w_cache_data = OOR_DATA;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_edge) w_next = (w_in_range && !w_hit) ? ISSUE : DONE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (bus.mem_ready || w_timeout) w_next = DONE;
            DONE:    if (!bus.sdram_ce) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_cpu_wait = w_edge;
        w_mem_rd   = 1'b0;
        w_mem_we   = 1'b0;
        case (r_state)
            ISSUE: begin
                w_cpu_wait = 1'b1;
                w_mem_rd   = r_rnw;
                w_mem_we   = !r_rnw;
            end
            WAIT:    w_cpu_wait = 1'b1;
            default: ;
        endcase
    end

    // Edge register resets high so a strobe held across reset is not
    // mistaken for a fresh request.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_ce_q        <= 1'b1;
            r_rnw         <= 1'b1;
            r_cnt         <= '0;
            r_mem_addr    <= '0;
            r_mem_din     <= '0;
            r_ram_dout    <= 8'hFF;
            r_timeout_err <= 1'b0;
        end else begin
            r_ce_q <= bus.sdram_ce;
            case (r_state)
                IDLE: begin
                    if (w_edge) begin
                        if (w_hit) begin
                            r_ram_dout <= w_cache_data;
                        end else if (w_in_range) begin
                            r_mem_addr <= bus.ram_addr;
                            r_mem_din  <= bus.ram_din;
                            r_rnw      <= bus.ram_rnw;
                        end else if (bus.ram_rnw) begin
                            r_ram_dout <= OOR_DATA;
                        end
                    end
                end
                ISSUE: r_cnt <= '0;
                WAIT: begin
                    if (bus.mem_ready) begin
                        if (r_rnw) r_ram_dout <= bus.mem_dout;
                    end else if (w_timeout) begin
                        r_ram_dout    <= OOR_DATA;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cpu_wait = w_cpu_wait;
    assign bus.mem_rd   = w_mem_rd;
    assign bus.mem_we   = w_mem_we;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_din  = r_mem_din;
    assign bus.ram_dout = r_ram_dout;
    assign timeout_err  = r_timeout_err;
endmodule
`default_nettype wire
